hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the write-enable and clear inputs of the F, D and E pipeline registers.
- Detects load-use hazards, conflicts with the multi-cycle mult/div unit, and flush requests from branch resolution.
- Holds the mult/div busy counter and a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use / mult-div / flush hazard control for the 5-stage MIPS core.
// Revision : 1.0
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      instr_e,
    input  logic             flush_d,
    output logic             we_f,
    output logic             we_d,
    output logic             clear_d,
    output logic             clear_e,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MD_W    = $clog2(MAX_LAT + 1);

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0] op_d, op_e, funct_d, funct_e;
    logic [4:0] rs_d, rt_d, rt_e;
    logic       load_e, uses_rt_d, md_op_d, md_op_e, md_div_e;
    logic       hilo_op_d, lu_hazard, md_hazard, stall;
    logic       unused_bits;

    assign op_d    = instr_d[31:26];
    assign rs_d    = instr_d[25:21];
    assign rt_d    = instr_d[20:16];
    assign funct_d = instr_d[5:0];
    assign op_e    = instr_e[31:26];
    assign rt_e    = instr_e[20:16];
    assign funct_e = instr_e[5:0];

    assign unused_bits = ^{instr_d[15:6], instr_e[25:21], instr_e[15:6]};

    always_comb begin
        load_e = 1'b0;
        case (op_e)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: load_e = (rt_e != 5'd0);
            default:                           load_e = 1'b0;
        endcase

        uses_rt_d = 1'b0;
        case (op_d)
            6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: uses_rt_d = 1'b1;
            default:                                  uses_rt_d = 1'b0;
        endcase
    end

    // funct 0x18..0x1B: bit 1 separates div (0x1A/0x1B) from mult (0x18/0x19)
    assign md_op_d   = (op_d == 6'h00) && (funct_d[5:2] == 4'b0110);
    assign md_op_e   = (op_e == 6'h00) && (funct_e[5:2] == 4'b0110);
    assign md_div_e  = funct_e[1];
    assign hilo_op_d = ((op_d == 6'h00) && (funct_d[5:2] == 4'b0100)) || md_op_d;

    // rs is compared regardless of instruction format, conservatively
    assign lu_hazard = load_e && ((rs_d == rt_e) || (uses_rt_d && (rt_d == rt_e)));
    assign md_busy   = (md_cnt_q != '0);
    assign md_hazard = md_busy && hilo_op_d;
    assign stall     = (lu_hazard || md_hazard) && !flush_d;

    assign we_f      = !stall;
    assign we_d      = !stall;
    assign clear_e   = stall;
    assign clear_d   = flush_d;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_op_e && !md_busy)
            md_cnt_d = md_div_e ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
        else if (md_busy)
            md_cnt_d = md_cnt_q - MD_W'(1);

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire
